regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised successor to the MIPS register file. It holds `2**ADDR_WIDTH` registers of `DATA_WIDTH` bits and provides two combinational read ports and two prioritised write ports: A for ALU writeback and B for load return. Read ports see same-cycle writes through write-through bypass. A per-register pending scoreboard lets the decode stage detect RAW hazards on producers still in flight. The block sits between decode (reads, issue) and writeback (writes) in the pipeline.

## Interface
- `DATA_WIDTH`, 32, register width in bits
- `ADDR_WIDTH`, 5, register index width; depth = `2**ADDR_WIDTH`
- `ZERO_REG`, 1, when 1, register 0 reads as 0, ignores writes and is never pending

- `clock_in`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `regWrite`  in  1  write enable, port A (high priority)
- `writeReg`  in  ADDR_WIDTH  port A target index
- `writeData`  in  DATA_WIDTH  port A data
- `regWrite2`  in  1  write enable, port B (low priority)
- `writeReg2`  in  ADDR_WIDTH  port B target index
- `writeData2`  in  DATA_WIDTH  port B data
- `readReg1`, `readReg2`  in  ADDR_WIDTH  read indices
- `readData1`, `readData2`  out  DATA_WIDTH  read data, combinational
- `issueValid`  in  1  marks `issueReg` pending (producer issued)
- `issueReg`  in  ADDR_WIDTH  register whose producer is issuing
- `busy1`, `busy2`  out  1  pending status of `readReg1` and `readReg2`

## Operation
- Storage: `regs[0..2**ADDR_WIDTH-1]` and `pending[0..2**ADDR_WIDTH-1]`.
- Write: at the rising edge, an enabled port writes its data to its target.
- Write collision: if both ports target the same index, port A's data is stored and port B's write is dropped.
- Zero register: with `ZERO_REG=1`, writes and issues to index 0 are ignored.
- Read value (per port X), chosen in this priority order:
  - 0 if `ZERO_REG` and the index is 0;
  - else `writeData` if `regWrite` and `writeReg` equals the index;
  - else `writeData2` if `regWrite2` and `writeReg2` equals the index;
  - else `regs[index]`.
- Scoreboard update at the rising edge:
  - `pending[issueReg]` is set when `issueValid`.
  - `pending[i]` is cleared by any enabled write to i (either port).
  - Issue and write to the same index in one cycle: set wins, because the new producer supersedes the old one.
- Busy (per port X):
  - `busyX = pending[readRegX]` unless an enabled write targets `readRegX` this cycle; in that case `busyX = 0`, consistent with the bypassed data.
  - `busyX` is always 0 for index 0 when `ZERO_REG`.
  - An issue in the current cycle does not affect `busyX` until the next cycle.
- Reset (`reset`=0, asynchronous):
  - All `regs` are cleared to 0 and all `pending` bits to 0 immediately.
  - `readData1`/`readData2` = 0 and `busy1`/`busy2` = 0 while reset is held, regardless of write inputs.
  - Writes and issues presented during reset are discarded.
  - Reset released mid-operation leaves no partial state.

## Timing
- Read latency is 0 cycles: combinational from the read index, the stored state and same-cycle write inputs.
- A write is visible in the same cycle through bypass, and from storage from the next cycle onward.
- Pending state is visible on `busyX` in the cycle after `issueValid`.
- Deassertion of `reset` is assumed to be synchronised externally. The first write is accepted at the first rising edge with `reset`=1.
- There are no combinational paths from `issueValid`/`issueReg` to the outputs.

## Test plan
- Write/read: write 32'hFFFF0000 to reg 21 and 32'h0000FFFF to reg 10 on consecutive edges, then set `regWrite`=0 and read reg 21 / reg 10. Required: `readData1`=32'hFFFF0000, `readData2`=32'h0000FFFF.
- Async reset mid-operation: with the previous values stored, drive `reset`=0 between clock edges. Required: both read outputs go to 0 immediately without waiting for a clock edge; after release, reg 21 and reg 10 read 0.
- Bypass and collision:
  - `regWrite`=1 to reg 5 with 32'h12345678, `readReg1`=5 in the same cycle. Required: `readData1`=32'h12345678 before the edge.
  - Both ports write reg 7, A with 32'hAAAA0000 and B with 32'h0000BBBB. Required: reg 7 reads 32'hAAAA0000 next cycle.
- Zero register: write 32'hDEADBEEF to reg 0 and issue reg 0. Required: `readData1`=0 and `busy1`=0 in every cycle.
- Scoreboard: issue reg 3 → next cycle `busy1`=1 (readReg1=3). Port B write to reg 3 → `busy1`=0 in that cycle and stays 0 afterwards. Issue and port A write to reg 3 in the same cycle → `busy1`=1 in the next cycle.
- Parametrisation: `DATA_WIDTH`=16, `ADDR_WIDTH`=3, `ZERO_REG`=0. Write 16'hBEEF to reg 7 and 16'h0001 to reg 0. Required: reg 7 reads 16'hBEEF and reg 0 reads 16'h0001.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with two combinational read ports, two prioritised write
//   ports (A = ALU writeback, high priority; B = load return, low priority),
//   write-through bypass and a per-register pending scoreboard for RAW
//   hazard detection at decode.
//
// Ports
//   clock_in              clock, rising edge
//   reset                 asynchronous active-low reset
//   regWrite/writeReg/writeData      write port A
//   regWrite2/writeReg2/writeData2   write port B
//   readReg1/readReg2     read indices
//   readData1/readData2   combinational read data (bypassed)
//   issueValid/issueReg   mark a register pending (producer issued)
//   busy1/busy2           pending status of readReg1/readReg2
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite2,
  input  logic [ADDR_WIDTH-1:0] writeReg2,
  input  logic [DATA_WIDTH-1:0] writeData2,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueReg,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pending_q;
  logic [DEPTH-1:0]      pending_d;

  logic wr_a_en;
  logic wr_b_en;
  logic issue_en;

  // Register 0 is filtered out of every state-changing path up front, so
  // storage and scoreboard never need to special-case it.
  assign wr_a_en  = regWrite   && !(ZR && (writeReg  == '0));
  assign wr_b_en  = regWrite2  && !(ZR && (writeReg2 == '0));
  assign issue_en = issueValid && !(ZR && (issueReg  == '0));

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Port A wins a collision; port B's write is dropped.
        if (wr_a_en && (writeReg == ADDR_WIDTH'(i))) begin
          regs_q[i] <= writeData;
        end else if (wr_b_en && (writeReg2 == ADDR_WIDTH'(i))) begin
          regs_q[i] <= writeData2;
        end
      end
    end
  end

  // Clear on write first, then set on issue: a new producer supersedes the
  // one completing in the same cycle.
  always_comb begin
    pending_d = pending_q;
    if (wr_a_en) pending_d[writeReg]  = 1'b0;
    if (wr_b_en) pending_d[writeReg2] = 1'b0;
    if (issue_en) pending_d[issueReg] = 1'b1;
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Outputs are forced low while reset is held so that bypassed write data
  // cannot leak out during reset.
  always_comb begin
    readData1 = '0;
    busy1     = 1'b0;
    if (reset && !(ZR && (readReg1 == '0))) begin
      if (wr_a_en && (writeReg == readReg1)) begin
        readData1 = writeData;
      end else if (wr_b_en && (writeReg2 == readReg1)) begin
        readData1 = writeData2;
      end else begin
        readData1 = regs_q[readReg1];
        busy1     = pending_q[readReg1];
      end
    end
  end

  always_comb begin
    readData2 = '0;
    busy2     = 1'b0;
    if (reset && !(ZR && (readReg2 == '0))) begin
      if (wr_a_en && (writeReg == readReg2)) begin
        readData2 = writeData;
      end else if (wr_b_en && (writeReg2 == readReg2)) begin
        readData2 = writeData2;
      end else begin
        readData2 = regs_q[readReg2];
        busy2     = pending_q[readReg2];
      end
    end
  end

endmodule
